// File: rtl/fifo_uart_tx_amisha.sv
// UART transmitter that drains a byte FIFO: pops one word per frame and shifts it
// out as start bit, DBIT data bits LSB-first, then STOP_BITS stop bits.
module fifo_uart_tx_amisha #(
  parameter int DBIT_amisha         = 8,
  parameter int CLKS_PER_BIT_amisha = 16,
  parameter int STOP_BITS_amisha    = 1
) (
  input  logic                   clk_amisha,
  input  logic                   reset_amisha,
  input  logic                   tx_en_amisha,
  input  logic                   fifo_empty_amisha,
  input  logic [DBIT_amisha-1:0] fifo_r_data_amisha,
  output logic                   fifo_rd_amisha,
  output logic                   tx_amisha,
  output logic                   busy_amisha,
  output logic                   done_tick_amisha
);

  localparam int TW = (CLKS_PER_BIT_amisha > 2) ? $clog2(CLKS_PER_BIT_amisha) : 1;
  localparam int IW = (DBIT_amisha > 2) ? $clog2(DBIT_amisha) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT_amisha - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DBIT_amisha - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS_amisha - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DBIT_amisha-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pop;

  // Gated by reset so a pop can never coincide with a reset edge.
  assign pop            = (state_q == IDLE) & tx_en_amisha & ~fifo_empty_amisha & reset_amisha;
  assign fifo_rd_amisha = pop;
  assign tx_amisha        = tx_q;
  assign busy_amisha      = busy_q;
  assign done_tick_amisha = done_q;

  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = START;
          shift_d = fifo_r_data_amisha;
          tick_d  = '0;
          idx_d   = '0;
        end
      end
      START: begin
        if (tick_q == TICK_LAST) begin
          state_d = DATA;
          tick_d  = '0;
          idx_d   = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (idx_q == BIT_LAST) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STOP: begin
        // idx counts stop-bit periods here so the tick counter stays one bit period wide.
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up with state_q.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (tick_d == TICK_LAST) && (idx_d == STOP_LAST);
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_amisha.sv
// Drives two transmitters (16 clk/bit 1 stop, 4 clk/bit 2 stop) from modelled FIFOs and
// compares every cycle against a frame-position reference model.
module tb_fifo_uart_tx_amisha;

  localparam int CPB0 = 16, SB0 = 1, CPB1 = 4, SB1 = 2;
  localparam int FLEN0 = (9 + SB0) * CPB0;
  localparam int FLEN1 = (9 + SB1) * CPB1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic [1:0] empty;
  logic [1:0] rd, tx, busy, done;
  logic [7:0] rdata [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         pos [2];
  logic [7:0] cur [2];
  logic [1:0] exp_rd;
  int         pops [2];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_amisha #(.DBIT_amisha(8), .CLKS_PER_BIT_amisha(CPB0), .STOP_BITS_amisha(SB0)) dut0 (
    .clk_amisha(clk), .reset_amisha(rst_n), .tx_en_amisha(tx_en),
    .fifo_empty_amisha(empty[0]), .fifo_r_data_amisha(rdata[0]),
    .fifo_rd_amisha(rd[0]), .tx_amisha(tx[0]), .busy_amisha(busy[0]),
    .done_tick_amisha(done[0]));

  fifo_uart_tx_amisha #(.DBIT_amisha(8), .CLKS_PER_BIT_amisha(CPB1), .STOP_BITS_amisha(SB1)) dut1 (
    .clk_amisha(clk), .reset_amisha(rst_n), .tx_en_amisha(tx_en),
    .fifo_empty_amisha(empty[1]), .fifo_r_data_amisha(rdata[1]),
    .fifo_rd_amisha(rd[1]), .tx_amisha(tx[1]), .busy_amisha(busy[1]),
    .done_tick_amisha(done[1]));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line level at cycle p of a frame (p<0 means idle).
  function automatic logic exp_tx(input int p, input int cpb, input logic [7:0] d);
    int b;
    if (p < 0) return 1'b1;
    b = p / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic refresh();
    empty[0] = (q0.size() == 0);
    empty[1] = (q1.size() == 0);
    rdata[0] = empty[0] ? 8'($urandom) : q0[0];
    rdata[1] = empty[1] ? 8'($urandom) : q1[0];
  endtask

  task automatic push(input logic [7:0] b);
    q0.push_back(b);
    q1.push_back(b);
  endtask

  // One clock: check the pop strobe, advance the model at the edge, check registered outputs.
  task automatic tick();
    int flen;
    int cpb;
    refresh();
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rd[k] = (pos[k] < 0) && tx_en && !empty[k] && rst_n;
      check_eq($sformatf("fifo_rd%0d", k), 32'(rd[k]), 32'(exp_rd[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      flen = (k == 0) ? FLEN0 : FLEN1;
      if (!rst_n) begin
        pos[k] = -1;
      end else if (pos[k] < 0) begin
        if (exp_rd[k]) begin
          pos[k] = 0;
          pops[k]++;
          if (k == 0) cur[0] = q0.pop_front();
          else        cur[1] = q1.pop_front();
        end
      end else begin
        pos[k]++;
        if (pos[k] == flen) pos[k] = -1;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      flen = (k == 0) ? FLEN0 : FLEN1;
      cpb  = (k == 0) ? CPB0 : CPB1;
      check_eq($sformatf("tx%0d", k),   32'(tx[k]),   32'(exp_tx(pos[k], cpb, cur[k])));
      check_eq($sformatf("busy%0d", k), 32'(busy[k]), 32'(pos[k] >= 0));
      check_eq($sformatf("done%0d", k), 32'(done[k]), 32'(pos[k] == flen - 1));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    tx_en = 1'b1;
    pos[0] = -1; pos[1] = -1;
    cur[0] = '0; cur[1] = '0;
    pops[0] = 0; pops[1] = 0;
    refresh();
    @(negedge clk);

    // reset, then idle with empty FIFO
    run(3);
    rst_n = 1'b1;
    run(200);

    // single frame 0xA5
    push(8'hA5);
    run(170);
    check_eq("pops_after_a5", 32'(pops[0]), 32'd1);

    // back-to-back frames
    push(8'h01); push(8'h80); push(8'hFF);
    run(3 * (FLEN0 + 1) + 20);
    check_eq("pops_after_3", 32'(pops[0]), 32'd4);
    check_eq("pops1_after_3", 32'(pops[1]), 32'd4);

    // tx_en gating; drop tx_en during data bit 3 of the first frame
    tx_en = 1'b0;
    push(8'h5A); push(8'hC3);
    run(30);
    tx_en = 1'b1;
    run(1 + 70);
    tx_en = 1'b0;
    run(200);
    check_eq("pops_en_gate", 32'(pops[0]), 32'd5);

    // reset mid-frame during data bit 4, then idle with empty FIFO
    q0.delete(); q1.delete();
    push(8'h3C);
    tx_en = 1'b1;
    run(1 + CPB0 + 4 * CPB0 + 5);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(60);

    // randomized traffic with enable toggles and occasional resets
    push(8'h55);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0 && q0.size() < 6 && q1.size() < 6) push(8'($urandom));
      if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    tx_en = 1'b1;
    run(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
